sub_slice_sequencer: RTL and testbench
======================================

Name: sub_slice_sequencer

Overview:
- Multi-cycle controller that runs 32-bit subtract, subtract-with-borrow, compare and negate operations through one shared 8-bit subtractor slice.
- The slice has 9-bit A/B/DIFF, CI is borrow-in, and DIFF = A - B - CI.
- The controller feeds the slice one byte per cycle, LSB first, and chains the borrow from byte to byte.
- It sits between the ALU issue logic (valid/ready request) and the writeback stage (valid/ready result). It also returns N/Z/C/V flags.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of SLICE.
- SLICE, 8, slice width in bits.
- NSLICE, WIDTH/SLICE, number of slice passes per operation (derived; not overridable).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready at a rising edge.
- in_op  in  2  operation select:
  - 00 SUB: A-B.
  - 01 SBB: A-B-in_bin.
  - 10 CMP: A-B, flags only.
  - 11 NEG: 0-A.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B (ignored for NEG).
- in_bin  in  1  borrow-in (used only for SBB).
- clr  in  1  synchronous abort: return to IDLE and drop any operation in progress.
- slice_en  out  1  slice operands valid this cycle.
- slice_a  out  SLICE+1  slice A operand, bit SLICE = 0.
- slice_b  out  SLICE+1  slice B operand, bit SLICE = 0.
- slice_ci  out  1  slice borrow-in.
- slice_diff  in  SLICE+1  slice result; [SLICE-1:0] = difference byte, [SLICE] = borrow-out. Combinational from slice_a/b/ci.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  consumer accepts result.
- out_res  out  WIDTH  difference.
- out_wen  out  1  0 for CMP, 1 otherwise.
- out_n, out_z, out_c, out_v  out  1 each  result flags:
  - N = res[WIDTH-1].
  - Z = (res == 0).
  - C = final borrow-out.
  - V = signed overflow of opA - opB.

Behaviour:
- Reset (async, rst=1):
  - State = IDLE; in_ready = 1; out_valid = 0.
  - out_res = 0; out_wen = 0; all flags = 0.
  - slice_en = 0; slice_a = 0; slice_b = 0; slice_ci = 0.
  - Internal byte index = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On accept: latch operands and move to RUN with idx = 0.
  - Latched operands: opA = in_a, opB = in_b, except NEG where opA = 0 and opB = in_a.
  - Latched op: in_op.
  - Latched borrow register: in_bin for SBB, else 0.
- RUN:
  - in_ready = 0; slice_en = 1.
  - slice_a = {0, opA[idx*8 +: 8]}; slice_b = {0, opB[idx*8 +: 8]}; slice_ci = borrow register.
  - At each edge: res[idx*8 +: 8] <= slice_diff[7:0]; borrow <= slice_diff[8]; idx++.
  - At the edge that consumes idx = NSLICE-1: go to DONE, set out_valid, register the flags, idx <= 0.
- DONE:
  - out_valid = 1; outputs stable while out_ready = 0.
  - On out_ready, go to IDLE.
  - No new request is accepted in the same cycle.
- Latency and throughput:
  - out_valid rises NSLICE edges after the accept edge (4 for the defaults).
  - Minimum initiation interval is NSLICE+2 cycles.
- Outside RUN: slice_en = 0 and slice_a/b/ci are driven 0.
- V = (opA[31] ^ opB[31]) & (opA[31] ^ res[31]).
  - Computed on latched operands, so NEG of 0x80000000 gives V = 1.
- C = 1 when unsigned opA < opB (+ bin), i.e. borrow semantics, not ARM carry.
- CMP: out_res still holds the difference; out_wen = 0.
- clr (synchronous, any state):
  - Next state IDLE; out_valid <= 0; idx <= 0.
  - out_res and flags retain their last values.
  - If clr and in_valid are both high in IDLE, clr wins: no accept.
- rst asserted mid-RUN or mid-DONE: immediate return to the reset values. The result is lost.
- Inputs in_a/b/op/bin may change after accept without affecting the operation in progress.

Test Plan:
- Basic SUB, no borrow:
  - Stimulus: SUB a=0x00000005, b=0x00000003.
  - Response: out_valid 4 cycles after accept; res=0x00000002; N=0 Z=0 C=0 V=0; wen=1.
  - Also check slice_ci=0, 0, 0, 0 across the 4 RUN cycles.
- Borrow ripple across all bytes:
  - Stimulus: SUB a=0x00000000, b=0x00000001.
  - Response: res=0xFFFFFFFF; N=1 C=1 V=0; slice_ci sequence 0, 1, 1, 1.
- Signed overflow and SBB:
  - Stimulus: SBB a=0x80000000, b=0x00000000, bin=1.
  - Response: res=0x7FFFFFFF; V=1 C=0 N=0.
- CMP and NEG:
  - Stimulus 1: CMP a=b=0x12345678. Response: res=0, Z=1, wen=0.
  - Stimulus 2: NEG a=0x80000000. Response: res=0x80000000, V=1, C=1.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid.
  - Response: out_valid and res stable; in_ready=0 throughout.
  - Then out_ready=1 gives IDLE next cycle; a new request is accepted the following edge.
- Abort and reset:
  - Stimulus 1: clr in the 2nd RUN cycle. Response: IDLE next edge, no out_valid, slice_en=0.
  - Stimulus 2: rst pulse between edges mid-RUN. Response: all outputs at reset values immediately, before the next edge.

Source files
------------

// File: rtl/sub_slice_sequencer.sv
// sub_slice_sequencer: runs 32-bit SUB/SBB/CMP/NEG byte-serially through an external 9-bit subtractor slice; ports: clk/rst, in_* request (valid/ready), clr abort, slice_* slice interface, out_* result (valid/ready) with N/Z/C/V flags
module sub_slice_sequencer #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_bin,
  input  logic             clr,
  output logic             slice_en,
  output logic [SLICE:0]   slice_a,
  output logic [SLICE:0]   slice_b,
  output logic             slice_ci,
  input  logic [SLICE:0]   slice_diff,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_wen,
  output logic             out_n,
  output logic             out_z,
  output logic             out_c,
  output logic             out_v
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d, res_q, res_d;
  logic [1:0]       op_q, op_d;
  logic             borrow_q, borrow_d, wen_q, wen_d;
  logic [3:0]       flags_q, flags_d;
  logic             last;
  assign last = idx_q == IW'(NSLICE - 1);
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    res_d    = res_q;
    op_d     = op_q;
    borrow_d = borrow_q;
    wen_d    = wen_q;
    flags_d  = flags_q;
    if (clr) begin
      state_d = IDLE;
      idx_d   = '0;
    end else if (state_q == IDLE && in_valid) begin
      state_d  = RUN;
      idx_d    = '0;
      op_a_d   = in_op == 2'b11 ? '0 : in_a;
      op_b_d   = in_op == 2'b11 ? in_a : in_b;
      op_d     = in_op;
      borrow_d = in_op == 2'b01 && in_bin;
    end else if (state_q == RUN) begin
      res_d[idx_q*SLICE +: SLICE] = slice_diff[SLICE-1:0];
      borrow_d = slice_diff[SLICE];
      idx_d    = last ? '0 : idx_q + 1'b1;
      if (last) begin
        state_d = DONE;
        wen_d   = op_q != 2'b10;
        // overflow judged on the latched operands, so NEG of the most negative value flags V
        flags_d = {res_d[WIDTH-1], res_d == '0, slice_diff[SLICE],
                   (op_a_q[WIDTH-1] ^ op_b_q[WIDTH-1]) & (op_a_q[WIDTH-1] ^ res_d[WIDTH-1])};
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      res_q    <= '0;
      op_q     <= '0;
      borrow_q <= 1'b0;
      wen_q    <= 1'b0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      res_q    <= res_d;
      op_q     <= op_d;
      borrow_q <= borrow_d;
      wen_q    <= wen_d;
      flags_q  <= flags_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign slice_en  = state_q == RUN;
  assign slice_a   = slice_en ? {1'b0, op_a_q[idx_q*SLICE +: SLICE]} : '0;
  assign slice_b   = slice_en ? {1'b0, op_b_q[idx_q*SLICE +: SLICE]} : '0;
  assign slice_ci  = slice_en && borrow_q;
  assign out_res   = res_q;
  assign out_wen   = wen_q;
  assign {out_n, out_z, out_c, out_v} = flags_q;
endmodule

// File: tb/tb_sub_slice_sequencer.sv
// tb_sub_slice_sequencer: directed bench with an arithmetic reference model and a per-cycle compare process
module tb_sub_slice_sequencer;
  logic        clk = 0, rst = 1, in_valid = 0, in_bin = 0, clr = 0, out_ready = 0;
  logic [1:0]  in_op = 0;
  logic [31:0] in_a = 0, in_b = 0;
  logic        in_ready, slice_en, slice_ci, out_valid, out_wen, out_n, out_z, out_c, out_v;
  logic [8:0]  slice_a, slice_b, slice_diff;
  logic [31:0] out_res;
  int checks = 0, failures = 0;
  logic        pending = 0;
  int          phase = 0;
  logic [31:0] exp_a, exp_b, exp_res;
  logic [3:0]  exp_nzcv, exp_ci;
  logic        exp_wen;

  sub_slice_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_bin(in_bin), .clr(clr), .slice_en(slice_en),
    .slice_a(slice_a), .slice_b(slice_b), .slice_ci(slice_ci), .slice_diff(slice_diff),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_wen(out_wen),
    .out_n(out_n), .out_z(out_z), .out_c(out_c), .out_v(out_v)
  );

  assign slice_diff = slice_a - slice_b - {8'd0, slice_ci};
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // reference: whole-word arithmetic; borrow into byte k is the borrow of the low k bytes
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic bin);
    logic [32:0] full, lo;
    logic [31:0] m;
    logic bi;
    longint sd;
    exp_a = op == 2'd3 ? 32'd0 : a;
    exp_b = op == 2'd3 ? a : b;
    bi = op == 2'd1 ? bin : 1'b0;
    full = {1'b0, exp_a} - {1'b0, exp_b} - {32'd0, bi};
    exp_res = full[31:0];
    sd = longint'($signed(exp_a)) - longint'($signed(exp_b)) - longint'(bi);
    exp_nzcv = {full[31], full[31:0] == 32'd0, full[32], sd > 64'sd2147483647 || sd < -64'sd2147483648};
    exp_wen = op != 2'd2;
    exp_ci[0] = bi;
    for (int k = 1; k < 4; k++) begin
      m = 32'hFFFF_FFFF >> (32 - 8 * k);
      lo = {1'b0, exp_a & m} - {1'b0, exp_b & m} - {32'd0, bi};
      exp_ci[k] = lo[32];
    end
  endtask

  always @(negedge clk) begin
    if (!pending) begin
      phase = 0;
      chk("idle_slice_en", {31'd0, slice_en}, 0);
      chk("idle_slice_ci", {31'd0, slice_ci}, 0);
      chk("idle_out_valid", {31'd0, out_valid}, 0);
    end else begin
      chk("busy_in_ready", {31'd0, in_ready}, 0);
      if (phase < 4) begin
        chk("run_slice_en", {31'd0, slice_en}, 1);
        chk("run_out_valid", {31'd0, out_valid}, 0);
        chk("run_slice_ci", {31'd0, slice_ci}, {31'd0, exp_ci[phase]});
        chk("run_slice_a", {23'd0, slice_a}, {24'd0, exp_a[phase*8 +: 8]});
        chk("run_slice_b", {23'd0, slice_b}, {24'd0, exp_b[phase*8 +: 8]});
      end else begin
        chk("done_out_valid", {31'd0, out_valid}, 1);
        chk("done_slice_en", {31'd0, slice_en}, 0);
        chk("done_res", out_res, exp_res);
        chk("done_nzcv", {28'd0, out_n, out_z, out_c, out_v}, {28'd0, exp_nzcv});
        chk("done_wen", {31'd0, out_wen}, {31'd0, exp_wen});
      end
      phase++;
    end
  end

  task automatic accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic bin);
    chk("accept_in_ready", {31'd0, in_ready}, 1);
    model(op, a, b, bin);
    in_valid = 1; in_op = op; in_a = a; in_b = b; in_bin = bin;
    @(posedge clk); #1;
    in_valid = 0; in_op = 2'($urandom); in_a = $urandom; in_b = $urandom; in_bin = 1'($urandom);
    pending = 1;
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic bin,
                       input logic [31:0] lit_res, input logic [3:0] lit_nzcv, input logic lit_wen, input int hold);
    int i;
    accept(op, a, b, bin);
    i = 0;
    while (!out_valid && i < 10) begin
      @(posedge clk); #1;
      i++;
    end
    chk("latency", i, 4);
    chk("lit_res", out_res, lit_res);
    chk("lit_nzcv", {28'd0, out_n, out_z, out_c, out_v}, {28'd0, lit_nzcv});
    chk("lit_wen", {31'd0, out_wen}, {31'd0, lit_wen});
    repeat (hold) begin
      @(posedge clk); #1;
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    pending = 0;
    chk("back_to_idle", {31'd0, in_ready}, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 1);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 0);
    chk({tag, "_res"}, out_res, 0);
    chk({tag, "_flags_wen"}, {27'd0, out_wen, out_n, out_z, out_c, out_v}, 0);
    chk({tag, "_slice"}, {13'd0, slice_en, slice_a, slice_b, slice_ci}, 0);
  endtask

  initial begin
    #2 chk_reset_vals("reset");
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    do_op(2'd0, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 4'b0000, 1'b1, 0);
    do_op(2'd0, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 4'b1010, 1'b1, 0);
    do_op(2'd1, 32'h8000_0000, 32'h0000_0000, 1'b1, 32'h7FFF_FFFF, 4'b0001, 1'b1, 0);
    do_op(2'd2, 32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 4'b0100, 1'b0, 0);
    do_op(2'd3, 32'h8000_0000, 32'h5555_5555, 1'b1, 32'h8000_0000, 4'b1011, 1'b1, 0);
    do_op(2'd0, 32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 4'b0000, 1'b1, 5);
    do_op(2'd1, 32'h0000_0100, 32'h0000_00FF, 1'b1, 32'h0000_0000, 4'b0100, 1'b1, 0);
    // abort during the second RUN cycle; flags keep the previous result
    accept(2'd0, 32'hDEAD_BEEF, 32'h0123_4567, 1'b0);
    @(posedge clk); #1;
    clr = 1;
    @(posedge clk); #1;
    clr = 0; pending = 0;
    chk("clr_in_ready", {31'd0, in_ready}, 1);
    chk("clr_slice_en", {31'd0, slice_en}, 0);
    chk("clr_flags", {28'd0, out_n, out_z, out_c, out_v}, 32'h4);
    repeat (6) @(posedge clk);
    #1;
    // clr beats a simultaneous request in IDLE
    clr = 1; in_valid = 1; in_op = 2'd0; in_a = 32'h10; in_b = 32'h1;
    @(posedge clk); #1;
    clr = 0; in_valid = 0;
    chk("clr_wins_in_ready", {31'd0, in_ready}, 1);
    chk("clr_wins_slice_en", {31'd0, slice_en}, 0);
    @(posedge clk); #1;
    // async reset between edges mid-RUN
    accept(2'd1, 32'hFFFF_0000, 32'h0000_FFFF, 1'b1);
    @(posedge clk); #2;
    rst = 1;
    #1;
    pending = 0;
    chk_reset_vals("async_rst");
    rst = 0;
    @(posedge clk); #1;
    do_op(2'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 4'b1011, 1'b1, 1);
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
